counter_n: RTL and testbench
============================

Name: counter_n

Overview:
Parametrised up/down counter that generalises the fixed 4-bit enable/reset counter. It adds width, a programmable modulus, direction control, synchronous clear and parallel load, and a wrap/saturate mode. It also reports terminal-count and rollover status for downstream timers, dividers and address generators. The next-state arithmetic lives in a small incrementer/decrementer sub-module, replacing the fixed 4-bit incrementer.

Parameters:
WIDTH, 4, counter width in bits; 1..32
MAX_VALUE, 2**WIDTH-1, top of count range (inclusive); 1 <= MAX_VALUE <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends
RESET_VALUE, 0, value loaded by reset and clear; must be <= MAX_VALUE

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
enable  in  1  count one step this cycle
clear  in  1  synchronous return to RESET_VALUE
load  in  1  synchronous parallel load
load_value  in  WIDTH  data for load
up  in  1  direction: 1 = increment, 0 = decrement
count  out  WIDTH  current registered value
terminal  out  1  combinational: high when count is at the end for current direction (MAX_VALUE if up=1, 0 if up=0)
rollover  out  1  registered one-cycle pulse: previous edge attempted a step past a range end
sticky_ovf  out  1  registered; set on any rollover event, cleared only by reset or clear

Behaviour:
- Reset (asynchronous, any time): count = RESET_VALUE, rollover = 0, sticky_ovf = 0. Outputs take these values while reset is high, independent of clock. Normal operation resumes on the first rising edge after deassertion.
- Per-edge priority: clear > load > enable > hold.
- clear: count <= RESET_VALUE, rollover <= 0, sticky_ovf <= 0.
- load: count <= min(load_value, MAX_VALUE); rollover <= 0; sticky_ovf unchanged. Out-of-range loads clamp and are not errors.
- enable, up=1, count < MAX_VALUE: count <= count+1.
- enable, up=0, count > 0: count <= count-1.
- enable, up=1, count == MAX_VALUE: wrap mode -> count <= 0; saturate mode -> count holds. Either way rollover <= 1 and sticky_ovf <= 1.
- enable, up=0, count == 0: wrap mode -> count <= MAX_VALUE; saturate mode -> count holds. Either way rollover <= 1 and sticky_ovf <= 1.
- No enable, clear or load: count holds; rollover <= 0.
- rollover is high for exactly the one cycle following each range-end step. Continuous enable at an end in saturate mode gives rollover high on every cycle.
- terminal is purely combinational from count and up. It may change in the same cycle that up toggles.
- Latency: count updates one edge after qualifying inputs. No pipelining.
- Arithmetic: WIDTH-bit unsigned. Carry/borrow out of the sub-module is not used for range detection; compare against MAX_VALUE and 0 explicitly, because the modulus may be a non-power-of-two.
- When MAX_VALUE == 2**WIDTH-1, wrap behaviour equals natural binary wrap.
- Elaboration must fail if the parameter constraints are violated.

Decomposition:
- Shared package counter_pkg holds the mode constants MODE_WRAP = 0 and MODE_SATURATE = 1, plus a helper function clamp(value, max).
- Sub-module inc_dec_n (parameter WIDTH; ports x, up, y, c_out) performs x+1 or x-1. It is the parametrised successor of the fixed 4-bit incrementer. c_out is left unconnected at the counter_n instance.
- counter_n holds the count register, the priority mux, end detection and the status flags.

Test Plan:
- WIDTH=4, MAX_VALUE=9, wrap; reset, enable, up=1 for 10 cycles -> count 1..9 then 0; rollover high only in the cycle after the 9->0 step; terminal high while count=9.
- Same config, up=0 from 0 with enable -> count 9; rollover pulses; sticky_ovf=1; clear -> count 0, sticky_ovf 0.
- SATURATE=1, MAX_VALUE=9; count up to 9 and hold enable 3 cycles -> count stays 9; rollover high all 3 cycles; down at 0 behaves symmetrically.
- load=1 with load_value=13, MAX_VALUE=9 -> count 9. load and enable together with load_value=3 -> count 3 (load wins). clear+load together -> RESET_VALUE.
- Assert reset mid-count at count=5, between clock edges -> count = RESET_VALUE immediately, flags 0. Release, one enable -> count RESET_VALUE+1.
- WIDTH=8, default MAX_VALUE, wrap; load 255, enable up -> count 0, rollover 1. Load 0, enable down -> count 255.

Source files
------------

// File: rtl/counter_pkg.sv
// +----------------------------------------------------------------------+
// | counter_pkg : shared mode constants and load clamp helper            |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package counter_pkg;

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_SATURATE = 1;

    function automatic logic [31:0] clamp(input logic [31:0] value, input logic [31:0] max_v);
        return (value > max_v) ? max_v : value;
    endfunction

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_n_inc_dec.sv
// +----------------------------------------------------------------------+
// | inc_dec_n : WIDTH-bit incrementer/decrementer with carry/borrow out  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module inc_dec_n #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic             up,
    output logic [WIDTH-1:0] y,
    output logic             c_out
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        if (up) begin
            w_sum = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            w_sum = {1'b0, x} - {{WIDTH{1'b0}}, 1'b1};
        end
    end

    assign y     = w_sum[WIDTH-1:0];
    assign c_out = w_sum[WIDTH];

endmodule : inc_dec_n

`default_nettype wire

// File: rtl/counter_n.sv
// +----------------------------------------------------------------------+
// | counter_n : up/down modulus counter with wrap/saturate and status    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module counter_n
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH       = 4,
    parameter longint unsigned MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     SATURATE    = MODE_WRAP,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             rollover,
    output logic             sticky_ovf
);

    generate
        if ((WIDTH < 1) || (WIDTH > 32) || (MAX_VALUE < 1) ||
            (MAX_VALUE > ((64'd1 << WIDTH) - 64'd1)) ||
            (RESET_VALUE > MAX_VALUE) || (SATURATE > MODE_SATURATE)) begin : g_param_check
            $error("counter_n: illegal parameter combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_max   = MAX_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_reset = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             rollover_q, rollover_d;
    logic             sticky_q, sticky_d;

    logic [WIDTH-1:0] w_step;
    logic             w_carry_unused;
    logic [WIDTH-1:0] w_load_value;
    logic             w_at_end;

    inc_dec_n #(
        .WIDTH (WIDTH)
    ) u_inc_dec (
        .x     (count_q),
        .up    (up),
        .y     (w_step),
        .c_out (w_carry_unused)
    );

    // Range ends are explicit compares so non-power-of-two moduli work.
    assign w_at_end     = up ? (count_q == c_max) : (count_q == '0);
    assign w_load_value = WIDTH'(clamp(32'(load_value), 32'(c_max)));

    always_comb begin
        count_d    = count_q;
        rollover_d = 1'b0;
        sticky_d   = sticky_q;
        if (clear) begin
            count_d  = c_reset;
            sticky_d = 1'b0;
        end else if (load) begin
            count_d = w_load_value;
        end else if (enable) begin
            if (w_at_end) begin
                rollover_d = 1'b1;
                sticky_d   = 1'b1;
                if (SATURATE == MODE_WRAP) begin
                    count_d = up ? '0 : c_max;
                end
            end else begin
                count_d = w_step;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= c_reset;
            rollover_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
            sticky_q   <= sticky_d;
        end
    end

    assign count      = count_q;
    assign terminal   = w_at_end;
    assign rollover   = rollover_q;
    assign sticky_ovf = sticky_q;

endmodule : counter_n

`default_nettype wire

// File: tb/tb_counter_n.sv
// +----------------------------------------------------------------------+
// | tb_counter_n : directed vector bench for wrap, saturate and 8-bit    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_counter_n;

    logic       clk;
    logic       rst;
    logic       en, clr, ld, up;
    logic [3:0] lv;

    logic       c_en, c_clr, c_ld, c_up;
    logic [7:0] c_lv;

    logic [3:0] a_cnt, b_cnt;
    logic       a_term, a_roll, a_stk;
    logic       b_term, b_roll, b_stk;
    logic [7:0] c_cnt;
    logic       c_term, c_roll, c_stk;

    int n_checks = 0;
    int n_fail   = 0;

    counter_n #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0), .RESET_VALUE(0)) u_wrap (
        .clock(clk), .reset(rst), .enable(en), .clear(clr), .load(ld),
        .load_value(lv), .up(up), .count(a_cnt), .terminal(a_term),
        .rollover(a_roll), .sticky_ovf(a_stk)
    );

    counter_n #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1), .RESET_VALUE(3)) u_sat (
        .clock(clk), .reset(rst), .enable(en), .clear(clr), .load(ld),
        .load_value(lv), .up(up), .count(b_cnt), .terminal(b_term),
        .rollover(b_roll), .sticky_ovf(b_stk)
    );

    counter_n #(.WIDTH(8)) u_w8 (
        .clock(clk), .reset(rst), .enable(c_en), .clear(c_clr), .load(c_ld),
        .load_value(c_lv), .up(c_up), .count(c_cnt), .terminal(c_term),
        .rollover(c_roll), .sticky_ovf(c_stk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr, ld, en, up;
        logic [3:0] lv;
        logic [3:0] a_cnt;
        logic       a_roll, a_stk;
        logic [3:0] b_cnt;
        logic       b_roll, b_stk;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic c, input logic l, input logic e, input logic u,
                                input logic [3:0] v, input logic [3:0] ac, input logic ar,
                                input logic as, input logic [3:0] bc, input logic br,
                                input logic bs);
        vec_t t;
        t.clr = c; t.ld = l; t.en = e; t.up = u; t.lv = v;
        t.a_cnt = ac; t.a_roll = ar; t.a_stk = as;
        t.b_cnt = bc; t.b_roll = br; t.b_stk = bs;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {en, clr, ld, up} = 4'b0;
        lv = 4'd0;
        {c_en, c_clr, c_ld, c_up} = 4'b0;
        c_lv = 8'd0;

        //            clr ld en up lv  | A cnt roll stk | B cnt roll stk
        vecs[0]  = mk(0, 0, 1, 1, 0,   1, 0, 0,   4, 0, 0);
        vecs[1]  = mk(0, 0, 1, 1, 0,   2, 0, 0,   5, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 0,   3, 0, 0,   6, 0, 0);
        vecs[3]  = mk(0, 0, 1, 1, 0,   4, 0, 0,   7, 0, 0);
        vecs[4]  = mk(0, 0, 1, 1, 0,   5, 0, 0,   8, 0, 0);
        vecs[5]  = mk(0, 0, 1, 1, 0,   6, 0, 0,   9, 0, 0);
        vecs[6]  = mk(0, 0, 1, 1, 0,   7, 0, 0,   9, 1, 1);
        vecs[7]  = mk(0, 0, 1, 1, 0,   8, 0, 0,   9, 1, 1);
        vecs[8]  = mk(0, 0, 1, 1, 0,   9, 0, 0,   9, 1, 1);
        vecs[9]  = mk(0, 0, 1, 1, 0,   0, 1, 1,   9, 1, 1);
        vecs[10] = mk(0, 0, 0, 1, 0,   0, 0, 1,   9, 0, 1);
        vecs[11] = mk(0, 0, 1, 0, 0,   9, 1, 1,   8, 0, 1);
        vecs[12] = mk(0, 0, 1, 0, 0,   8, 0, 1,   7, 0, 1);
        vecs[13] = mk(1, 0, 0, 0, 0,   0, 0, 0,   3, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 0,   9, 1, 1,   2, 0, 0);
        vecs[15] = mk(0, 0, 1, 0, 0,   8, 0, 1,   1, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 0,   7, 0, 1,   0, 0, 0);
        vecs[17] = mk(0, 0, 1, 0, 0,   6, 0, 1,   0, 1, 1);
        vecs[18] = mk(0, 0, 1, 0, 0,   5, 0, 1,   0, 1, 1);
        vecs[19] = mk(0, 1, 0, 1, 13,  9, 0, 1,   9, 0, 1);
        vecs[20] = mk(0, 1, 1, 1, 3,   3, 0, 1,   3, 0, 1);
        vecs[21] = mk(1, 1, 1, 1, 7,   0, 0, 0,   3, 0, 0);
        vecs[22] = mk(0, 0, 1, 1, 0,   1, 0, 0,   4, 0, 0);
        vecs[23] = mk(0, 1, 0, 1, 9,   9, 0, 0,   9, 0, 0);
        vecs[24] = mk(0, 0, 1, 1, 0,   0, 1, 1,   9, 1, 1);
        vecs[25] = mk(0, 1, 1, 0, 15,  9, 0, 1,   9, 0, 1);

        // Reset values must appear with no clock edge having occurred.
        #2;
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        chk("rst_a_flags", {30'd0, a_roll, a_stk}, 32'd0);
        chk("rst_b_cnt", 32'(b_cnt), 32'd3);
        chk("rst_b_flags", {30'd0, b_roll, b_stk}, 32'd0);
        chk("rst_c_cnt", 32'(c_cnt), 32'd0);
        #6 rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            clr = vecs[i].clr; ld = vecs[i].ld; en = vecs[i].en;
            up  = vecs[i].up;  lv = vecs[i].lv;
            tick();
            chk($sformatf("v%0d_a_cnt", i), 32'(a_cnt), 32'(vecs[i].a_cnt));
            chk($sformatf("v%0d_a_roll", i), 32'(a_roll), 32'(vecs[i].a_roll));
            chk($sformatf("v%0d_a_stk", i), 32'(a_stk), 32'(vecs[i].a_stk));
            chk($sformatf("v%0d_a_term", i), 32'(a_term),
                32'(vecs[i].up ? (vecs[i].a_cnt == 4'd9) : (vecs[i].a_cnt == 4'd0)));
            chk($sformatf("v%0d_b_cnt", i), 32'(b_cnt), 32'(vecs[i].b_cnt));
            chk($sformatf("v%0d_b_roll", i), 32'(b_roll), 32'(vecs[i].b_roll));
            chk($sformatf("v%0d_b_stk", i), 32'(b_stk), 32'(vecs[i].b_stk));
            chk($sformatf("v%0d_b_term", i), 32'(b_term),
                32'(vecs[i].up ? (vecs[i].b_cnt == 4'd9) : (vecs[i].b_cnt == 4'd0)));
        end

        // Terminal follows up combinationally: A at 9, flip direction.
        clr = 0; ld = 0; en = 0; up = 1;
        #1 chk("term_up_at9", 32'(a_term), 32'd1);
        up = 0;
        #1 chk("term_dn_at9", 32'(a_term), 32'd0);

        // Load 5, then assert reset between edges.
        ld = 1; lv = 4'd5; up = 1;
        tick();
        chk("mid_a_cnt", 32'(a_cnt), 32'd5);
        chk("mid_b_cnt", 32'(b_cnt), 32'd5);
        ld = 0; en = 1;
        tick();
        chk("pre_rst_a_stk", 32'(a_stk), 32'd1);
        en = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_a_cnt", 32'(a_cnt), 32'd0);
        chk("async_a_flags", {30'd0, a_roll, a_stk}, 32'd0);
        chk("async_b_cnt", 32'(b_cnt), 32'd3);
        chk("async_b_flags", {30'd0, b_roll, b_stk}, 32'd0);
        #2 rst = 1'b0;
        en = 1; up = 1;
        tick();
        chk("post_rst_a_cnt", 32'(a_cnt), 32'd1);
        chk("post_rst_b_cnt", 32'(b_cnt), 32'd4);
        en = 0;

        // 8-bit default-modulus counter: natural binary wrap both ways.
        c_ld = 1; c_lv = 8'd255; c_up = 1;
        tick();
        chk("w8_load255", 32'(c_cnt), 32'd255);
        chk("w8_term255", 32'(c_term), 32'd1);
        c_ld = 0; c_en = 1;
        tick();
        chk("w8_wrap_up_cnt", 32'(c_cnt), 32'd0);
        chk("w8_wrap_up_roll", 32'(c_roll), 32'd1);
        chk("w8_wrap_up_stk", 32'(c_stk), 32'd1);
        c_en = 0;
        tick();
        chk("w8_roll_pulse", 32'(c_roll), 32'd0);
        c_ld = 1; c_lv = 8'd0;
        tick();
        c_ld = 0; c_en = 1; c_up = 0;
        tick();
        chk("w8_wrap_dn_cnt", 32'(c_cnt), 32'd255);
        chk("w8_wrap_dn_roll", 32'(c_roll), 32'd1);
        c_en = 0; c_clr = 1;
        tick();
        chk("w8_clr_cnt", 32'(c_cnt), 32'd0);
        chk("w8_clr_stk", 32'(c_stk), 32'd0);
        c_clr = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_counter_n

`default_nettype wire
